uart_tx_arbiter: RTL

Shares the single transmit side of the `uart` core among `NUM_REQ` independent byte producers, such as an echo path, a status reporter and a debug dump. Each producer uses a valid/ready byte stream with a `last` marker. Once a producer is granted, it keeps the UART until its packet is fully sent. Grants rotate round-robin between packets, and the block drives the UART's `tx_data`/load inputs while pacing on `tx_empty`.

---
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART transmitter among NUM_REQ byte streams
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_LEN      = 8,
  parameter int IDLE_TIMEOUT  = 1024,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         lock_drop,
  output logic                         tx_err,
  output logic [DATA_LEN-1:0]          uart_tx_data,
  output logic                         uart_tx_load,
  input  logic                         uart_tx_empty
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam int SW = $clog2(START_TIMEOUT);
  typedef enum logic [1:0] {ARB, LOAD, WAIT_BUSY, WAIT_EMPTY} state_t;
  state_t state;
  logic [PW-1:0] ptr, win, gidx;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] start_cnt;
  logic last_q, hs;
  // descending scan so the nearest requester after ptr wins
  always_comb begin
    win = ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[PW'((int'(ptr) + k) % NUM_REQ)]) win = PW'((int'(ptr) + k) % NUM_REQ);
  end
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) gidx = PW'(i);
  end
  assign req_ready = (state == LOAD) ? grant & req_valid : '0;
  assign hs = |req_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
      grant <= '0;
      busy <= 1'b0;
      ptr <= PW'(NUM_REQ - 1);
      idle_cnt <= '0;
      start_cnt <= '0;
      last_q <= 1'b0;
      uart_tx_data <= '0;
      uart_tx_load <= 1'b0;
      lock_drop <= 1'b0;
      tx_err <= 1'b0;
    end else begin
      uart_tx_load <= 1'b0;
      lock_drop <= 1'b0;
      tx_err <= 1'b0;
      case (state)
        ARB: if (uart_tx_empty && |req_valid) begin
          grant <= NUM_REQ'(1) << win;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: if (hs) begin
          uart_tx_data <= req_data[int'(gidx)*DATA_LEN +: DATA_LEN];
          last_q <= |(req_last & grant);
          uart_tx_load <= 1'b1;
          idle_cnt <= '0;
          state <= WAIT_BUSY;
        end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
          lock_drop <= 1'b1;
          ptr <= gidx;
          grant <= '0;
          busy <= 1'b0;
          idle_cnt <= '0;
          state <= ARB;
        end else if (~&idle_cnt) idle_cnt <= idle_cnt + 1'b1;
        WAIT_BUSY: if (!uart_tx_empty) begin
          start_cnt <= '0;
          state <= WAIT_EMPTY;
        end else if (start_cnt == SW'(START_TIMEOUT - 1)) begin
          tx_err <= 1'b1;
          ptr <= gidx;
          grant <= '0;
          busy <= 1'b0;
          start_cnt <= '0;
          state <= ARB;
        end else start_cnt <= start_cnt + 1'b1;
        WAIT_EMPTY: if (uart_tx_empty) begin
          if (last_q) begin
            ptr <= gidx;
            grant <= '0;
            busy <= 1'b0;
            state <= ARB;
          end else state <= LOAD;
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule
